// File: rtl/fp64_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | fp64_pkg                                                                    |
// | binary64 field geometry, bias and class-flag bit positions for the unpacker |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
package fp64_pkg;

  localparam int EXP_W     = 11;
  localparam int FRAC_W    = 52;
  localparam int EXP_OUT_W = 12;
  localparam int BIAS      = 1023;
  localparam int EXP_MAX   = 2047;

  localparam int CLS_ZERO = 0;
  localparam int CLS_SUB  = 1;
  localparam int CLS_INF  = 2;
  localparam int CLS_NAN  = 3;
  localparam int CLS_SNAN = 4;
  localparam int CLS_W    = 5;

  typedef struct packed {
    logic exp_zero;
    logic exp_max;
    logic frac_zero;
  } s1_cls_t;

endpackage
`default_nettype wire

// File: rtl/lzc53.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | lzc53                                                                       |
// | Combinational 53-bit leading-zero counter; all-zero input yields 53         |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module lzc53 (
  input  logic [52:0] m_i,
  output logic [5:0]  cnt_o
);

  // Scanning upward lets the highest set bit win the final assignment.
  always_comb begin
    cnt_o = 6'd53;
    for (int i = 0; i < 53; i++) begin
      if (m_i[i]) cnt_o = 6'(52 - i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/fp64_operand_unpacker.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | fp64_operand_unpacker                                                       |
// | Two-stage valid/ready binary64 decoder: sign, unbiased exponent,            |
// | normalized 53-bit significand and class flags                               |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module fp64_operand_unpacker
  import fp64_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [63:0]          in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_sign,
  output logic [EXP_OUT_W-1:0] out_exp,
  output logic [FRAC_W:0]      out_sig,
  output logic                 out_zero,
  output logic                 out_sub,
  output logic                 out_inf,
  output logic                 out_nan,
  output logic                 out_snan
);

  logic                 s1_valid_q;
  logic                 s1_sign_q;
  logic [EXP_W-1:0]     s1_exp_q;
  logic [FRAC_W-1:0]    s1_frac_q;
  s1_cls_t              s1_cls_q;
  s1_cls_t              s1_cls_d;

  logic                 out_valid_q;
  logic                 out_sign_q;
  logic [EXP_OUT_W-1:0] out_exp_q;
  logic [FRAC_W:0]      out_sig_q;
  logic [CLS_W-1:0]     out_cls_q;

  logic [EXP_OUT_W-1:0] out_exp_d;
  logic [FRAC_W:0]      out_sig_d;
  logic [CLS_W-1:0]     out_cls_d;

  logic                 s1_adv;
  logic                 s2_adv;
  logic [FRAC_W:0]      sub_m;
  logic [5:0]           sub_lz;

  assign s2_adv   = !out_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  always_comb begin
    s1_cls_d.exp_zero  = (in_data[FRAC_W +: EXP_W] == '0);
    s1_cls_d.exp_max   = (in_data[FRAC_W +: EXP_W] == EXP_W'(EXP_MAX));
    s1_cls_d.frac_zero = (in_data[FRAC_W-1:0] == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_exp_q   <= '0;
      s1_frac_q  <= '0;
      s1_cls_q   <= '0;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_sign_q <= in_data[63];
        s1_exp_q  <= in_data[FRAC_W +: EXP_W];
        s1_frac_q <= in_data[FRAC_W-1:0];
        s1_cls_q  <= s1_cls_d;
      end
    end
  end

  assign sub_m = {1'b0, s1_frac_q};

  lzc53 u_lzc (
    .m_i   (sub_m),
    .cnt_o (sub_lz)
  );

  // Subnormal value is frac * 2^(1-BIAS-52); normalizing by lz gives exponent (1-BIAS) - lz.
  always_comb begin
    out_cls_d = '0;
    out_exp_d = '0;
    out_sig_d = {1'b1, s1_frac_q};
    if (s1_cls_q.exp_zero && s1_cls_q.frac_zero) begin
      out_cls_d[CLS_ZERO] = 1'b1;
      out_sig_d           = '0;
    end else if (s1_cls_q.exp_zero) begin
      out_cls_d[CLS_SUB] = 1'b1;
      out_sig_d          = sub_m << sub_lz;
      out_exp_d          = EXP_OUT_W'(1 - BIAS) - EXP_OUT_W'(sub_lz);
    end else if (s1_cls_q.exp_max && s1_cls_q.frac_zero) begin
      out_cls_d[CLS_INF] = 1'b1;
    end else if (s1_cls_q.exp_max) begin
      out_cls_d[CLS_NAN]  = 1'b1;
      out_cls_d[CLS_SNAN] = !s1_frac_q[FRAC_W-1];
    end else begin
      out_exp_d = EXP_OUT_W'(s1_exp_q) - EXP_OUT_W'(BIAS);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_sign_q  <= 1'b0;
      out_exp_q   <= '0;
      out_sig_q   <= '0;
      out_cls_q   <= '0;
    end else if (s2_adv) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_sign_q <= s1_sign_q;
        out_exp_q  <= out_exp_d;
        out_sig_q  <= out_sig_d;
        out_cls_q  <= out_cls_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_sign  = out_sign_q;
  assign out_exp   = out_exp_q;
  assign out_sig   = out_sig_q;
  assign out_zero  = out_cls_q[CLS_ZERO];
  assign out_sub   = out_cls_q[CLS_SUB];
  assign out_inf   = out_cls_q[CLS_INF];
  assign out_nan   = out_cls_q[CLS_NAN];
  assign out_snan  = out_cls_q[CLS_SNAN];

endmodule
`default_nettype wire

// File: tb/tb_fp64_operand_unpacker.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_fp64_operand_unpacker                                                    |
// | Self-checking bench: directed literal cases plus randomized scoreboard run  |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tb_fp64_operand_unpacker;

  typedef struct packed {
    logic        sign;
    logic [11:0] exp;
    logic [52:0] sig;
    logic [4:0]  flags;  // {zero, sub, inf, nan, snan}
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_sign;
  logic [11:0] out_exp;
  logic [52:0] out_sig;
  logic        out_zero, out_sub, out_inf, out_nan, out_snan;

  int n_cmp = 0;
  int n_bad = 0;

  res_t sb_q[$];
  res_t sb_e;
  res_t prev_rec;
  logic prev_hold = 1'b0;

  fp64_operand_unpacker dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_exp   (out_exp),
    .out_sig   (out_sig),
    .out_zero  (out_zero),
    .out_sub   (out_sub),
    .out_inf   (out_inf),
    .out_nan   (out_nan),
    .out_snan  (out_snan)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h required %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired (t=%0t)", nm, $time);
  endtask

  // Value-level reference: a subnormal is frac * 2^-1074, so its leading one at bit p
  // sits at 2^(p-1074).
  function automatic res_t model(input logic [63:0] w);
    res_t        r;
    int          e;
    int          p;
    logic [51:0] f;
    e = int'(w[62:52]);
    f = w[51:0];
    r.sign  = w[63];
    r.exp   = '0;
    r.sig   = '0;
    r.flags = '0;
    if (e == 0 && f == 0) begin
      r.flags = 5'b10000;
    end else if (e == 0) begin
      p = -1;
      for (int i = 0; i < 52; i++) if (f[i]) p = i;
      r.exp   = 12'(p - 1074);
      r.sig   = 53'(f) << (52 - p);
      r.flags = 5'b01000;
    end else if (e == 2047 && f == 0) begin
      r.sig   = 53'h10000000000000;
      r.flags = 5'b00100;
    end else if (e == 2047) begin
      r.sig   = {1'b1, f};
      r.flags = {4'b0001, ~f[51]};
    end else begin
      r.exp = 12'(e - 1023);
      r.sig = {1'b1, f};
    end
    return r;
  endfunction

  function automatic res_t dut_rec();
    res_t r;
    r.sign  = out_sign;
    r.exp   = out_exp;
    r.sig   = out_sig;
    r.flags = {out_zero, out_sub, out_inf, out_nan, out_snan};
    return r;
  endfunction

  function automatic logic [63:0] rand_word();
    logic [63:0] r;
    int          c;
    r = {$urandom(), $urandom()};
    c = $urandom_range(0, 9);
    case (c)
      0: r[62:0] = '0;
      1, 2: begin
        r[62:52] = '0;
        r[51:0]  = r[51:0] >> $urandom_range(0, 51);
        if (r[51:0] == '0) r[0] = 1'b1;
      end
      3: begin
        r[62:52] = 11'h7FF;
        r[51:0]  = '0;
      end
      4: begin
        r[62:52] = 11'h7FF;
        if (r[51:0] == '0) r[0] = 1'b1;
      end
      5: r[62:52] = ($urandom_range(0, 1) == 0) ? 11'h001 : 11'h7FE;
      default: if (r[62:52] == '0 || r[62:52] == 11'h7FF) r[62:52] = 11'h400;
    endcase
    return r;
  endfunction

  // Scoreboard, hold-stability and ordering checks on every cycle.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_data", dut_rec(), prev_rec);
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_out", out_valid, 1'b0);
        end else begin
          sb_e = sb_q.pop_front();
          check("scoreboard", dut_rec(), sb_e);
        end
      end
      if (in_valid && in_ready) sb_q.push_back(model(in_data));
      prev_hold = out_valid && !out_ready;
      prev_rec  = dut_rec();
    end
  end

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] w);
    int t;
    t        = 0;
    in_valid = 1'b1;
    in_data  = w;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) fail_now("send_timeout");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic directed(input string nm, input logic [63:0] w, input logic sgn,
                          input logic [11:0] ex, input logic [52:0] sg, input logic [4:0] fl);
    int lat;
    align();
    out_ready = 1'b1;
    send(w);
    lat = 0;
    while (lat < 8) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    check({nm, "_latency"}, lat, 2);
    check({nm, "_sign"}, out_sign, sgn);
    check({nm, "_exp"}, out_exp, ex);
    check({nm, "_sig"}, out_sig, sg);
    check({nm, "_flags"}, {out_zero, out_sub, out_inf, out_nan, out_snan}, fl);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] ws [4];
    logic        done;
    int          t;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_outputs", dut_rec(), '0);

    directed("one",      64'h3FF0000000000000, 1'b0, 12'h000, 53'h10000000000000, 5'b00000);
    directed("min_sub",  64'h0000000000000001, 1'b0, 12'hBCE, 53'h10000000000000, 5'b01000);
    directed("max_lz1",  64'h0008000000000000, 1'b0, 12'hC01, 53'h10000000000000, 5'b01000);
    directed("neg_zero", 64'h8000000000000000, 1'b1, 12'h000, 53'h0,              5'b10000);
    directed("neg_inf",  64'hFFF0000000000000, 1'b1, 12'h000, 53'h10000000000000, 5'b00100);
    directed("snan",     64'h7FF0000000000001, 1'b0, 12'h000, 53'h10000000000001, 5'b00011);
    directed("qnan",     64'h7FF8000000000000, 1'b0, 12'h000, 53'h18000000000000, 5'b00010);
    directed("neg_0p75", 64'hBFE8000000000000, 1'b1, 12'hFFF, 53'h18000000000000, 5'b00000);

    // Stall: two accepts fill both stages, then the source must hold.
    ws[0] = 64'h4000000000000000;
    ws[1] = 64'h000000F000000000;
    ws[2] = 64'hC00123456789ABCD;
    ws[3] = 64'h7FF4000000000000;
    align();
    out_ready = 1'b0;
    send(ws[0]);
    send(ws[1]);
    in_valid = 1'b1;
    in_data  = ws[2];
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_in_ready", in_ready, 1'b0);
      check("stall_out_valid", out_valid, 1'b1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("drain_back_to_back", out_valid, 1'b1);
      if (k < 2) check("drain_in_ready", in_ready, 1'b1);
      @(posedge clk);
      #1;
      if (k == 0) in_data = ws[3];
      if (k == 1) in_valid = 1'b0;
    end
    @(negedge clk);
    check("drain_empty", out_valid, 1'b0);

    // Reset with two words in flight.
    align();
    out_ready = 1'b0;
    send(64'h3FF8000000000000);
    send(64'h0000000000000ABC);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_outputs", dut_rec(), '0);
    check("flush_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("flush_no_stale", out_valid, 1'b0);
    end

    // Randomized traffic with random backpressure.
    align();
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 250; i++) begin
          if ($urandom_range(0, 3) == 0) align();
          send(rand_word());
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    t = 0;
    while ((sb_q.size() != 0 || out_valid) && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (sb_q.size() != 0 || out_valid) fail_now("drain_random");
    check("random_all_consumed", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
